// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: decodes framed read/write commands from a UART byte stream into peripheral-bus requests.
// Define UART_BRIDGE_TIMEOUT_EN to abort a request that gets no response within TIMEOUT_CYCLES.
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        read,
    output logic        write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        response,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, BUS, SEND_ACK, SEND_DATA, SEND_ERR
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    state_t      state;
    logic        is_read;
    logic [1:0]  cnt;
    logic [31:0] result;
    logic        tx_ready;
`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] timer;
`endif

    // A strobe needs an idle transmitter and a quiet previous cycle, so pulses are at least 2 cycles apart.
    assign tx_ready = !tx_busy && !tx_en;

    // NOTE: every register here is updated with <= so all branches see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            cnt        <= 2'd0;
            result     <= '0;
            tx_en      <= 1'b0;
            tx_data    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            write_data <= '0;
            busy       <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            tx_en <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            if (state != BUS) timer <= '0;
`endif
            case (state)
                IDLE: if (rx_valid) begin
                    cnt  <= 2'd0;
                    busy <= 1'b1;
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_read <= (rx_data == OP_READ);
                        state   <= GET_ADDR;
                    end else begin
                        state <= SEND_ERR;
                    end
                end
                GET_ADDR: if (rx_valid) begin
                    address <= {rx_data, address[31:8]};
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        if (is_read) begin
                            read  <= 1'b1;
                            state <= BUS;
                        end else begin
                            state <= GET_DATA;
                        end
                    end
                end
                GET_DATA: if (rx_valid) begin
                    write_data <= {rx_data, write_data[31:8]};
                    cnt        <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        write <= 1'b1;
                        state <= BUS;
                    end
                end
                BUS: begin
                    // A response coinciding with expiry wins, so it is tested first.
                    if (response) begin
                        result <= read_data;
                        read   <= 1'b0;
                        write  <= 1'b0;
                        cnt    <= 2'd0;
                        state  <= SEND_ACK;
                    end
`ifdef UART_BRIDGE_TIMEOUT_EN
                    else if (timer == TIMEOUT_CYCLES - 1) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        cnt   <= 2'd0;
                        state <= SEND_ERR;
                    end else begin
                        timer <= timer + 32'd1;
                    end
`endif
                end
                SEND_ACK: if (tx_ready) begin
                    tx_en   <= 1'b1;
                    tx_data <= ACK_BYTE;
                    cnt     <= 2'd0;
                    if (is_read) begin
                        state <= SEND_DATA;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEND_DATA: if (tx_ready) begin
                    tx_en   <= 1'b1;
                    tx_data <= result[{cnt, 3'b000} +: 8];
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEND_ERR: if (tx_ready) begin
                    tx_en   <= 1'b1;
                    tx_data <= ERR_BYTE;
                    cnt     <= 2'd0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: frames are decoded by a reference model into expected bus
// requests and TX bytes; independent monitors compare what the DUT actually presents.
module tb_uart_bus_bridge;

    localparam int         TO_CYCLES = 16;
    localparam logic [7:0] ACK       = 8'hA5;
    localparam logic [7:0] ERR       = 8'hEE;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_txn_t;

    logic        clk;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;
    logic        busy;

    bus_txn_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] target_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    bit target_silent = 1'b0;
    int resp_delay = 0;
    int busy_left = 0;

    uart_bus_bridge #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .response   (response),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Output monitor: compares every TX strobe and every new bus request against the scoreboard.
    initial begin : monitor
        logic req_prev, resp_prev, txen_prev;
        bus_txn_t e;
        logic [7:0] eb;
        req_prev = 1'b0; resp_prev = 1'b0; txen_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                req_prev = 1'b0; resp_prev = 1'b0; txen_prev = 1'b0;
            end else begin
                if (tx_en) begin
                    check("tx_en_while_tx_busy", tx_busy, 1'b0);
                    check("tx_en_spacing", txen_prev, 1'b0);
                    if (exp_tx.size() == 0) flag_unexpected("tx_unexpected", tx_data);
                    else begin
                        eb = exp_tx.pop_front();
                        check("tx_byte", tx_data, eb);
                    end
                end
                if (resp_prev) check("req_drop_after_response", read || write, 1'b0);
                if ((read || write) && !req_prev) begin
                    check("rw_exclusive", read && write, 1'b0);
                    if (exp_bus.size() == 0) flag_unexpected("bus_unexpected", address);
                    else begin
                        e = exp_bus.pop_front();
                        check("bus_kind_write", write, e.is_wr);
                        check("bus_address", address, e.addr);
                        if (e.is_wr) check("bus_write_data", write_data, e.data);
                    end
                end
                resp_prev = response && (read || write);
                req_prev  = read || write;
                txen_prev = tx_en;
            end
        end
    end

    // Bus target: answers each request after resp_delay cycles unless silenced.
    initial begin : target
        int  wait_cnt;
        bit  done;
        wait_cnt = 0; done = 1'b0;
        response = 1'b0; read_data = '0;
        forever begin
            @(posedge clk); #1;
            response = 1'b0;
            if (!resetn || !(read || write)) begin
                wait_cnt = 0; done = 1'b0;
            end else if (!done && !target_silent) begin
                if (wait_cnt >= resp_delay) begin
                    response  = 1'b1;
                    done      = 1'b1;
                    read_data = (read && target_q.size() > 0) ? target_q.pop_front() : $urandom;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Transmitter model: busy for a random 0..8 cycles after each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en) busy_left = $urandom_range(0, 8);
        end
    end
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    function automatic byte_q_t wr_frame(input logic [31:0] a, input logic [31:0] d);
        byte_q_t q;
        q.push_back(8'h01);
        for (int i = 0; i < 4; i++) q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
        return q;
    endfunction

    function automatic byte_q_t rd_frame(input logic [31:0] a);
        byte_q_t q;
        q.push_back(8'h02);
        for (int i = 0; i < 4; i++) q.push_back(a[8*i +: 8]);
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Reference model: decode the frame into expected bus traffic and reply bytes, then send it.
    task automatic issue(input byte_q_t bytes, input logic [31:0] rdata, input bit expect_timeout);
        logic [31:0] a, d;
        bit valid_op;
        valid_op = (bytes[0] == 8'h01 || bytes[0] == 8'h02);
        if (valid_op) begin
            a = '0; d = '0;
            for (int i = 0; i < 4; i++) a[8*i +: 8] = bytes[1+i];
            if (bytes[0] == 8'h01) for (int i = 0; i < 4; i++) d[8*i +: 8] = bytes[5+i];
            exp_bus.push_back('{is_wr: (bytes[0] == 8'h01), addr: a, data: d});
            if (expect_timeout) exp_tx.push_back(ERR);
            else begin
                exp_tx.push_back(ACK);
                if (bytes[0] == 8'h02) begin
                    target_q.push_back(rdata);
                    for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
                end
            end
        end else begin
            exp_tx.push_back(ERR);
        end
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (i == 0 || i == bytes.size() - 1) begin
                @(negedge clk);
                if (i == 0) check("busy_after_opcode", busy, 1'b1);
                if (i == bytes.size() - 1 && valid_op) check("req_after_last_byte", read || write, 1'b1);
                @(posedge clk); #1;
            end else begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && exp_tx.size() == 0 && exp_bus.size() == 0;
        end
        check(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_en"}, tx_en, 1'b0);
        check({tag, "_read"}, read, 1'b0);
        check({tag, "_write"}, write, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_address"}, address, 32'h0);
        check({tag, "_write_data"}, write_data, 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        resetn = 1'b0;
        exp_tx.delete();
        exp_bus.delete();
        target_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero(tag);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        byte_q_t     f;
        logic [7:0]  op;
        int          hi;
        bit          seen;
        resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        resp_delay = 5;
        f = wr_frame(32'h0000_0010, 32'hDEAD_BEEF);
        issue(f, 32'h0, 1'b0);
        wait_idle("idle_after_write");

        resp_delay = 2;
        f = rd_frame(32'h0000_0000);
        issue(f, 32'h1234_5678, 1'b0);
        wait_idle("idle_after_read");

        f = {8'h7F};
        issue(f, 32'h0, 1'b0);
        wait_idle("idle_after_bad_opcode");

        target_silent = 1'b1;
        f = rd_frame(32'h0000_0040);
`ifdef UART_BRIDGE_TIMEOUT_EN
        issue(f, 32'h0, 1'b1);
        hi = 1;
        while (hi < 100) begin
            @(negedge clk);
            if (!read) break;
            hi++;
        end
        check("timeout_read_cycles", hi, TO_CYCLES);
        @(posedge clk); #1;
        target_silent = 1'b0;
        wait_idle("idle_after_timeout");
`else
        issue(f, 32'hCAFE_F00D, 1'b0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("read_held_without_timeout", read, 1'b1);
        @(posedge clk); #1;
        target_silent = 1'b0;
        wait_idle("idle_after_long_read");
`endif

        target_silent = 1'b1;
        f = wr_frame(32'h0000_1000, 32'h5555_AAAA);
        issue(f, 32'h0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        apply_reset("rst_in_bus");
        target_silent = 1'b0;
        send_byte(8'h01); send_byte(8'h44); send_byte(8'h33);
        apply_reset("rst_in_addr");
        resp_delay = 3;
        f = wr_frame(32'h0000_2004, 32'h0BAD_F00D);
        issue(f, 32'h0, 1'b0);
        wait_idle("idle_after_reset_recovery");

        resp_delay = 1;
        f = rd_frame($urandom);
        issue(f, $urandom, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = tx_en;
        end
        check("ack_seen_before_junk", seen, 1'b1);
        @(posedge clk); #1;
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h7F);
        wait_idle("idle_after_junk");

        for (int n = 0; n < 20; n++) begin
            resp_delay = $urandom_range(0, 6);
            case ($urandom_range(0, 2))
                0: f = wr_frame($urandom, $urandom);
                1: f = rd_frame($urandom);
                default: begin
                    op = 8'($urandom_range(0, 255));
                    if (op == 8'h01 || op == 8'h02) op = 8'h80;
                    f = {op};
                end
            endcase
            issue(f, $urandom, 1'b0);
            wait_idle("idle_after_random");
        end

        check("leftover_target_data", target_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
